// File: rtl/matrix.sv
// Four-state transition-matrix stepper: advances (P, S, L, TI) by one step of a
// 4x4 matrix built from nine 5-bit coefficients (units of 1/32); TI is absorbing.
module matrix (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set,
    input  logic        start,
    input  logic [4:0]  e12_in,
    input  logic [4:0]  e13_in,
    input  logic [4:0]  e14_in,
    input  logic [4:0]  e21_in,
    input  logic [4:0]  e23_in,
    input  logic [4:0]  e24_in,
    input  logic [4:0]  e31_in,
    input  logic [4:0]  e32_in,
    input  logic [4:0]  e34_in,
    input  logic [31:0] xp,
    input  logic [31:0] xs,
    input  logic [31:0] xl,
    input  logic [31:0] xti,
    output logic [31:0] xpn,
    output logic [31:0] xsn,
    output logic [31:0] xln,
    output logic [31:0] xtin,
    output logic [7:0]  xn,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ROW1 = 3'd1,
        ROW2 = 3'd2,
        ROW3 = 3'd3,
        UPD  = 3'd4
    } state_t;

    state_t state_r;
    state_t next_s;

    logic [4:0]  c12_r, c13_r, c14_r;
    logic [4:0]  c21_r, c23_r, c24_r;
    logic [4:0]  c31_r, c32_r, c34_r;

    logic [31:0] wp_r, ws_r, wl_r, wti_r;

    logic [33:0] in_p_r, in_s_r, in_l_r, in_ti_r;
    logic [33:0] out_p_r, out_s_r, out_l_r;

    logic [31:0] src_s;
    logic [4:0]  ca_s, cb_s, cc_s;
    logic [31:0] fa_s, fb_s, fc_s;
    logic [33:0] out_row_s;

    logic        idle_s;
    logic        capture_s;

    // floor(x * e / 32) using the full 37-bit product
    function automatic logic [31:0] flow(input logic [31:0] x, input logic [4:0] e);
        logic [36:0] prod;
        prod = {5'd0, x} * {32'd0, e};
        return 32'(prod >> 5);
    endfunction

    // x + in - out evaluated signed, saturated into the unsigned 32-bit range
    function automatic logic [31:0] sat_next(input logic [31:0] x,
                                             input logic [33:0] in_v,
                                             input logic [33:0] out_v);
        logic signed [35:0] sum;
        logic [31:0]        res;
        sum = $signed({4'd0, x}) + $signed({2'd0, in_v}) - $signed({2'd0, out_v});
        if (sum < 36'sd0) begin
            res = 32'd0;
        end else if (sum > 36'sh0FFFFFFFF) begin
            res = 32'hFFFF_FFFF;
        end else begin
            res = 32'(sum);
        end
        return res;
    endfunction

    assign idle_s    = (state_r == IDLE);
    assign capture_s = idle_s && start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic: start only matters in IDLE, rows run back to back
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_s = ROW1;
                end else begin
                    next_s = IDLE;
                end
            end
            ROW1:    next_s = ROW2;
            ROW2:    next_s = ROW3;
            ROW3:    next_s = UPD;
            UPD:     next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Coefficient registers; set is honoured only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c12_r <= 5'd0; c13_r <= 5'd0; c14_r <= 5'd0;
            c21_r <= 5'd0; c23_r <= 5'd0; c24_r <= 5'd0;
            c31_r <= 5'd0; c32_r <= 5'd0; c34_r <= 5'd0;
        end else if (idle_s && set) begin
            c12_r <= e12_in; c13_r <= e13_in; c14_r <= e14_in;
            c21_r <= e21_in; c23_r <= e23_in; c24_r <= e24_in;
            c31_r <= e31_in; c32_r <= e32_in; c34_r <= e34_in;
        end
    end

    // Snapshot of the population taken at the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_r  <= 32'd0;
            ws_r  <= 32'd0;
            wl_r  <= 32'd0;
            wti_r <= 32'd0;
        end else if (capture_s) begin
            wp_r  <= xp;
            ws_r  <= xs;
            wl_r  <= xl;
            wti_r <= xti;
        end
    end

    // Row select: one source population and its three outgoing coefficients
    always_comb begin
        src_s = 32'd0;
        ca_s  = 5'd0;
        cb_s  = 5'd0;
        cc_s  = 5'd0;
        case (state_r)
            ROW1: begin
                src_s = wp_r; ca_s = c12_r; cb_s = c13_r; cc_s = c14_r;
            end
            ROW2: begin
                src_s = ws_r; ca_s = c21_r; cb_s = c23_r; cc_s = c24_r;
            end
            ROW3: begin
                src_s = wl_r; ca_s = c31_r; cb_s = c32_r; cc_s = c34_r;
            end
            default: begin
                src_s = 32'd0; ca_s = 5'd0; cb_s = 5'd0; cc_s = 5'd0;
            end
        endcase
    end

    assign fa_s      = flow(src_s, ca_s);
    assign fb_s      = flow(src_s, cb_s);
    assign fc_s      = flow(src_s, cc_s);
    assign out_row_s = {2'd0, fa_s} + {2'd0, fb_s} + {2'd0, fc_s};

    // Inflow/outflow accumulators; fa/fb/fc go to the non-source states in order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_p_r  <= 34'd0; in_s_r  <= 34'd0;
            in_l_r  <= 34'd0; in_ti_r <= 34'd0;
            out_p_r <= 34'd0; out_s_r <= 34'd0; out_l_r <= 34'd0;
        end else if (capture_s) begin
            in_p_r  <= 34'd0; in_s_r  <= 34'd0;
            in_l_r  <= 34'd0; in_ti_r <= 34'd0;
            out_p_r <= 34'd0; out_s_r <= 34'd0; out_l_r <= 34'd0;
        end else begin
            case (state_r)
                ROW1: begin
                    in_s_r  <= in_s_r  + {2'd0, fa_s};
                    in_l_r  <= in_l_r  + {2'd0, fb_s};
                    in_ti_r <= in_ti_r + {2'd0, fc_s};
                    out_p_r <= out_row_s;
                end
                ROW2: begin
                    in_p_r  <= in_p_r  + {2'd0, fa_s};
                    in_l_r  <= in_l_r  + {2'd0, fb_s};
                    in_ti_r <= in_ti_r + {2'd0, fc_s};
                    out_s_r <= out_row_s;
                end
                ROW3: begin
                    in_p_r  <= in_p_r  + {2'd0, fa_s};
                    in_s_r  <= in_s_r  + {2'd0, fb_s};
                    in_ti_r <= in_ti_r + {2'd0, fc_s};
                    out_l_r <= out_row_s;
                end
                default: begin
                    in_p_r  <= in_p_r;
                    in_s_r  <= in_s_r;
                    in_l_r  <= in_l_r;
                    in_ti_r <= in_ti_r;
                end
            endcase
        end
    end

    // Result registers and step counter, written only in UPD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpn  <= 32'd0;
            xsn  <= 32'd0;
            xln  <= 32'd0;
            xtin <= 32'd0;
            xn   <= 8'd0;
        end else if (state_r == UPD) begin
            xpn  <= sat_next(wp_r,  in_p_r,  out_p_r);
            xsn  <= sat_next(ws_r,  in_s_r,  out_s_r);
            xln  <= sat_next(wl_r,  in_l_r,  out_l_r);
            xtin <= sat_next(wti_r, in_ti_r, 34'd0);
            xn   <= xn + 8'd1;
        end
    end

    // One-cycle completion pulse aligned with the result update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state_r == UPD);
        end
    end

endmodule

// File: tb/tb_matrix.sv
// Directed self-checking bench for matrix with hand-computed expected values.
module tb_matrix;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        set;
    logic        start;
    logic [4:0]  e12_in, e13_in, e14_in, e21_in, e23_in, e24_in, e31_in, e32_in, e34_in;
    logic [31:0] xp, xs, xl, xti;
    logic [31:0] xpn, xsn, xln, xtin;
    logic [7:0]  xn;
    logic        done;

    int errors = 0;
    int checks = 0;

    matrix dut (
        .clk(clk), .rst_n(rst_n), .set(set), .start(start),
        .e12_in(e12_in), .e13_in(e13_in), .e14_in(e14_in),
        .e21_in(e21_in), .e23_in(e23_in), .e24_in(e24_in),
        .e31_in(e31_in), .e32_in(e32_in), .e34_in(e34_in),
        .xp(xp), .xs(xs), .xl(xl), .xti(xti),
        .xpn(xpn), .xsn(xsn), .xln(xln), .xtin(xtin),
        .xn(xn), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic drive_coef(input logic [4:0] a, b, c, d, e, f, g, h, i);
        e12_in = a; e13_in = b; e14_in = c;
        e21_in = d; e23_in = e; e24_in = f;
        e31_in = g; e32_in = h; e34_in = i;
    endtask

    task automatic drive_pop(input logic [31:0] p, s, l, t);
        xp = p; xs = s; xl = l; xti = t;
    endtask

    // Counts falling edges until done is seen, bounded
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 20);
    endtask

    task automatic step(output int lat);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(lat);
    endtask

    task automatic check_nominal(input string tag);
        check({tag, "_xpn"},  xpn,  32'd1258611);
        check({tag, "_xsn"},  xsn,  32'd219251);
        check({tag, "_xln"},  xln,  32'd216799);
        check({tag, "_xtin"}, xtin, 32'd341922);
    endtask

    initial begin
        int lat;
        int timeouts;
        logic saw_done;

        rst_n = 1'b0; set = 1'b0; start = 1'b0;
        drive_coef(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        drive_pop(32'd5, 32'd6, 32'd7, 32'd8);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_xpn", xpn, 32'd0);
        check("rst_xtin", xtin, 32'd0);
        check("rst_xn", {24'd0, xn}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_xsn", xsn, 32'd0);
        check("post_rst_xln", xln, 32'd0);
        check("post_rst_done", {31'd0, done}, 32'd0);

        // Nominal step; inputs change after capture and must not matter
        drive_coef(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9);
        set = 1'b1;
        @(negedge clk) set = 1'b0;
        drive_pop(32'd1412442, 32'd124241, 32'd436436, 32'd63464);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        drive_pop(32'd99, 32'd98, 32'd97, 32'd96);
        wait_done(lat);
        check("nom_latency", lat, 32'd4);
        check_nominal("nom");
        check("nom_xn", {24'd0, xn}, 32'd1);
        check("nom_sum", xpn + xsn + xln + xtin, 32'd2036583);
        @(negedge clk);
        check("nom_done_width", {31'd0, done}, 32'd0);
        check("nom_hold_xpn", xpn, 32'd1258611);

        // Identity with zero coefficients
        drive_coef(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk) set = 1'b1;
        @(negedge clk) set = 1'b0;
        drive_pop(32'd123456789, 32'hDEADBEEF, 32'd0, 32'd42);
        step(lat);
        check("id_latency", lat, 32'd4);
        check("id_xpn", xpn, 32'd123456789);
        check("id_xsn", xsn, 32'hDEADBEEF);
        check("id_xln", xln, 32'd0);
        check("id_xtin", xtin, 32'd42);
        check("id_xn", {24'd0, xn}, 32'd2);

        // Saturation at the top of the range
        drive_coef(5'd0, 5'd0, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk) set = 1'b1;
        @(negedge clk) set = 1'b0;
        drive_pop(32'h1000, 32'd0, 32'd0, 32'hFFFF_FFF0);
        step(lat);
        check("clamp_xtin", xtin, 32'hFFFF_FFFF);
        check("clamp_xpn", xpn, 32'h80);
        check("clamp_xsn", xsn, 32'd0);
        check("clamp_xn", {24'd0, xn}, 32'd3);

        // set+start together, then set/start again during ROW2 with other coefficients
        @(negedge clk);
        drive_coef(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9);
        drive_pop(32'd1412442, 32'd124241, 32'd436436, 32'd63464);
        set = 1'b1; start = 1'b1;
        @(negedge clk);
        set = 1'b0; start = 1'b0;
        drive_coef(5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31);
        @(negedge clk);
        set = 1'b1; start = 1'b1;
        @(negedge clk);
        set = 1'b0; start = 1'b0;
        wait_done(lat);
        check("busy_latency", lat, 32'd2);
        check_nominal("busy");
        check("busy_xn", {24'd0, xn}, 32'd4);
        step(lat);
        check_nominal("coef_kept");
        check("coef_kept_xn", {24'd0, xn}, 32'd5);

        // Counter wrap
        timeouts = 0;
        for (int k = 0; k < 250; k++) begin
            step(lat);
            if (done !== 1'b1) timeouts++;
        end
        check("wrap_pre_xn", {24'd0, xn}, 32'd255);
        step(lat);
        check("wrap_xn", {24'd0, xn}, 32'd0);
        check("wrap_timeouts", timeouts, 32'd0);

        // Abort: reset asserted just after E2
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_xpn", xpn, 32'd0);
        check("abort_xsn", xsn, 32'd0);
        check("abort_xtin", xtin, 32'd0);
        check("abort_xn", {24'd0, xn}, 32'd0);
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        check("abort_xln_after", xln, 32'd0);
        check("abort_xn_after", {24'd0, xn}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix.md
# matrix

Fixed-point 4-state transition-matrix stepper: one start request advances a population vector (P, S, L, TI) by one step of a 4×4 transition matrix. The matrix is defined by nine programmable 5-bit coefficients. State TI is absorbing. The block is a leaf datapath/FSM; a controller loads coefficients with `set`, then issues `start` pulses, and the host samples the result on `done`.

## Interface
- No parameters. Widths are fixed: population 32 bits, coefficient 5 bits, step counter 8 bits.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- set  in  1  load coefficient registers from e*_in (level, sampled each edge)
- start  in  1  request one step (sampled each edge)
- e12_in, e13_in, e14_in  in  5 each  coefficients, flow from state 1 (P) to S, L, TI
- e21_in, e23_in, e24_in  in  5 each  coefficients, flow from state 2 (S) to P, L, TI
- e31_in, e32_in, e34_in  in  5 each  coefficients, flow from state 3 (L) to P, S, TI
- xp, xs, xl, xti  in  32 each  current population of P, S, L, TI (unsigned)
- xpn, xsn, xln, xtin  out  32 each  registered next population
- xn  out  8  count of completed steps
- done  out  1  one-cycle pulse when xpn..xtin are updated

## Operation
- Coefficient e_ij is the fraction of state i that moves to state j, in units of 1/32.
- Coefficient registers reset to 0. While the FSM is in IDLE, every edge with set=1 loads all nine registers. set is ignored while busy.
- Flow per coefficient: f_ij = floor(x_i · e_ij / 32). Use a 37-bit product, then shift right by 5; the result fits in 32 bits.
- Outflow and inflow:
  - out_i = sum of f_ij over j, for i = 1..3.
  - in_j = sum of f_ij over i. State 4 (TI) has no outflows.
- Next value: x_j' = x_j + in_j − out_j, computed signed at 35 bits or wider. Clamp to 0 if negative and to 0xFFFFFFFF if above that value.
- With row sums ≤ 32 and no overflow, total population is conserved exactly.
- FSM states:
  - IDLE: start=1 captures xp/xs/xl/xti into working registers and moves to ROW1. start is ignored in every other state.
  - ROW1, ROW2, ROW3: each computes the three flows of one source row with three 32×5 multipliers and accumulates in/out sums.
  - UPD: registers xpn..xtin, sets xn ← xn+1 (wraps 255→0), sets done=1, returns to IDLE.
- Outputs hold their value between steps. If no coefficients were loaded, a step copies the inputs to the outputs.

## Timing
- Reset (asynchronous, rst_n=0): xpn=xsn=xln=xtin=0, xn=0, done=0, coefficients=0, FSM=IDLE.
- Edge E0: start sampled high in IDLE. Inputs are captured at this edge; later changes to inputs do not affect the step in progress.
- E1, E2, E3: ROW1, ROW2, ROW3 computed.
- E4: outputs, xn and done update. Latency from start edge to result is 4 cycles.
- done is high from E4 to E5 only. A start sampled at E5 begins a new step, so throughput is one step per 5 cycles.
- set and start high on the same edge in IDLE: the coefficients load first, and the step uses the newly loaded coefficients.
- Reset asserted mid-step aborts the step: all registers return to reset values immediately and no done pulse is produced.

## Test plan
- Reset: with rst_n=0 → all outputs 0, done=0; after release, outputs stay 0 until the first step.
- Nominal step. Stimulus: set with e12..e34 = 1,2,3,4,5,6,7,8,9; inputs xp=1412442, xs=124241, xl=436436, xti=63464; then start. Required response 4 cycles later: xpn=1258611, xsn=219251, xln=216799, xtin=341922, xn=1, done pulse one cycle wide. The output sum equals 2036583.
- Identity: coefficients 0, any inputs, start → outputs equal inputs, xn increments.
- Clamp: xti=0xFFFFFFF0, xp=0x1000, e14=31, others 0, start. Required response: xtin=0xFFFFFFFF (clamped) and xpn=0x80.
- Busy protection: start and set pulsed during ROW2 with different coefficients → result equals the nominal step; the coefficient registers are unchanged.
- Counter wrap and abort: 256 steps → xn returns to 0. Then start, and drop rst_n at E2 → everything reads 0 and no done pulse appears.
